// File: rtl/mdu_sequencer_if.sv
// Start/busy/done handshake bundle between the EX stage and the multiply/divide unit.
interface mdu_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, src1, src2, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, src1, src2, flush,
        output busy, done, result
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// RISC-V sign, divide-by-zero and overflow rules, one op in flight at a time.
module mdu_sequencer #(
    parameter int unsigned XLEN         = 32,
    parameter bit          FAST_SPECIAL = 1'b1
) (
    input logic           clk,
    input logic           rst,
    mdu_sequencer_if.slave mdu
);
    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q;
    logic                neg_q;
    logic                spec_q;
    logic [XLEN-1:0]     spec_val_q;
    logic [XLEN-1:0]     opnd_q;
    logic [2*XLEN-1:0]   prod_q;
    logic [CW-1:0]       cnt_q;
    logic [XLEN-1:0]     result_q;

    // Operand decode, evaluated on the live inputs at acceptance
    logic                is_div, s1_signed, s2_signed, sign1, sign2;
    logic [XLEN-1:0]     abs1, abs2;
    logic                div_zero, div_ovf, special, res_neg, accept;
    logic [XLEN-1:0]     spec_val;

    always_comb begin
        is_div    = mdu.op[2];
        s1_signed = (mdu.op == 3'd1) || (mdu.op == 3'd2) || (mdu.op == 3'd4) || (mdu.op == 3'd6);
        s2_signed = (mdu.op == 3'd1) || (mdu.op == 3'd4) || (mdu.op == 3'd6);
        sign1     = mdu.src1[XLEN-1] & s1_signed;
        sign2     = mdu.src2[XLEN-1] & s2_signed;
        abs1      = sign1 ? -mdu.src1 : mdu.src1;
        abs2      = sign2 ? -mdu.src2 : mdu.src2;
        div_zero  = is_div && (mdu.src2 == '0);
        div_ovf   = is_div && !mdu.op[0] && (mdu.src1 == {1'b1, {(XLEN-1){1'b0}}})
                    && (mdu.src2 == '1);
        special   = div_zero || div_ovf;
        if (div_zero)
            spec_val = mdu.op[1] ? mdu.src1 : '1;
        else
            spec_val = mdu.op[1] ? '0 : mdu.src1;
        res_neg   = (is_div && mdu.op[1]) ? sign1 : (sign1 ^ sign2);
        accept    = (state_q == IDLE) && mdu.start && !mdu.flush;
    end

    // One iteration of each algorithm on the shared 2*XLEN register
    logic [XLEN:0]       add_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       rem_sh, diff;
    logic                no_borrow;
    logic [2*XLEN-1:0]   div_next;

    always_comb begin
        add_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? opnd_q : '0)};
        mul_next  = {add_sum, prod_q[XLEN-1:1]};
        rem_sh    = prod_q[2*XLEN-1:XLEN-1];
        diff      = rem_sh - {1'b0, opnd_q};
        no_borrow = !diff[XLEN];
        div_next  = {(no_borrow ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]),
                     prod_q[XLEN-2:0], no_borrow};
    end

    // Product is negated as a whole; quotient/remainder are negated after word select
    logic [2*XLEN-1:0]   mul_full;
    logic [XLEN-1:0]     div_word, fix_val;

    always_comb begin
        mul_full = neg_q ? -prod_q : prod_q;
        div_word = op_q[1] ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
        if (spec_q)
            fix_val = spec_val_q;
        else if (op_q[2])
            fix_val = neg_q ? -div_word : div_word;
        else if (op_q[1:0] == 2'b00)
            fix_val = mul_full[XLEN-1:0];
        else
            fix_val = mul_full[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        mdu.busy = 1'b0;
        mdu.done = 1'b0;
        case (state_q)
            IDLE: if (accept) state_d = (special && FAST_SPECIAL) ? DONE : CALC;
            CALC: begin
                mdu.busy = 1'b1;
                if (cnt_q == CW'(XLEN - 1)) state_d = FIX;
            end
            FIX: begin
                mdu.busy = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                mdu.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (mdu.flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= '0;
            neg_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            opnd_q     <= '0;
            prod_q     <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
        end else if (accept) begin
            op_q       <= mdu.op;
            neg_q      <= res_neg;
            spec_q     <= special;
            spec_val_q <= spec_val;
            cnt_q      <= '0;
            opnd_q     <= is_div ? abs2 : abs1;
            prod_q     <= {{XLEN{1'b0}}, (is_div ? abs1 : abs2)};
            if (special && FAST_SPECIAL) result_q <= spec_val;
        end else if (!mdu.flush) begin
            if (state_q == CALC) begin
                prod_q <= op_q[2] ? div_next : mul_next;
                cnt_q  <= cnt_q + CW'(1);
            end else if (state_q == FIX) begin
                result_q <= fix_val;
            end
        end
    end

    assign mdu.result = result_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed-vector bench for mdu_sequencer: results, latency, special cases,
// flush/abort, held start and mid-op reset.
module tb_mdu_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdu_sequencer_if #(.XLEN(32)) bus ();

    mdu_sequencer #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .mdu (bus)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy_cycles);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src1  = a;
        bus.src2  = b;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        lat         = 0;
        busy_cycles = 0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            if (bus.busy) busy_cycles++;
            if (bus.done) begin
                lat = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        res = bus.result;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$] = '{
        '{3'd0, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 34},
        '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34},
        '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34},
        '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34},
        '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34},
        '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34},
        '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34},
        '{3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 34},
        '{3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34},
        '{3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 34},
        '{3'd5, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, 1},
        '{3'd7, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 1},
        '{3'd4, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 1},
        '{3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1},
        '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
        '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res, last, r1, r2;
        int          lat, bc, ndone, c1, c2;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.src1  = '0;
        bus.src2  = '0;
        bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        last = '0;
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, bc);
            check($sformatf("v%0d_result", i), res, vecs[i].exp);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_busy_cycles", i), 32'(bc), (vecs[i].lat == 34) ? 32'd33 : 32'd0);
            @(posedge clk); #1;
            check($sformatf("v%0d_done_pulse", i), {30'd0, bus.busy, bus.done}, 32'd0);
            last = vecs[i].exp;
        end

        // Flush at start+10 aborts a DIV without a done pulse
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd4; bus.src1 = 32'd100; bus.src2 = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("flush_busy_before", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_busy_after", 32'(bus.busy), 32'd0);
        ndone = 0;
        repeat (40) begin
            if (bus.done) ndone++;
            @(posedge clk); #1;
        end
        check("flush_no_done", 32'(ndone), 32'd0);
        check("flush_result_kept", bus.result, last);
        run_op(3'd0, 32'd3, 32'd5, res, lat, bc);
        check("restart_mul_result", res, 32'h0000_000F);
        check("restart_mul_latency", 32'(lat), 32'd34);

        // Flush and start together in IDLE: nothing accepted
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd0; bus.src1 = 32'd4; bus.src2 = 32'd4;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        check("flush_start_busy", {30'd0, bus.busy, bus.done}, 32'd0);
        @(posedge clk); #1;
        check("flush_start_idle", {30'd0, bus.busy, bus.done}, 32'd0);

        // Start held high: second op accepted only after DONE, operands not relatched mid-op
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.src1 = 32'd2; bus.src2 = 32'd3;
        @(posedge clk); #1;
        ndone = 0; c1 = 0; c2 = 0; r1 = '0; r2 = '0;
        for (int cyc = 1; cyc <= 69; cyc++) begin
            if (cyc == 5) bus.src1 = 32'd9;
            if (bus.done) begin
                ndone++;
                if (ndone == 1) begin r1 = bus.result; c1 = cyc; end
                else begin r2 = bus.result; c2 = cyc; end
            end
            if (cyc == 69) bus.start = 1'b0;
            else begin
                @(posedge clk); #1;
            end
        end
        check("held_done_count", 32'(ndone), 32'd2);
        check("held_first_cycle", 32'(c1), 32'd34);
        check("held_first_result", r1, 32'd6);
        check("held_second_cycle", 32'(c2), 32'd69);
        check("held_second_result", r2, 32'd27);

        // Reset in the middle of CALC clears all outputs
        @(posedge clk); #1;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.src1 = 32'd11; bus.src2 = 32'd13;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("rst_mid_busy_before", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_done", 32'(bus.done), 32'd0);
        check("rst_mid_result", bus.result, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
